// File: rtl/mcu_blok_siralayici_pkg.sv
// Shared types for the MCU block sequencer: state encoding, component IDs and
// the pixel/position widths used on the IDCT-side interface.
`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif
`ifndef BLOCK_BIT
`define BLOCK_BIT 3
`endif

package mcu_blok_siralayici_pkg;

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    Y     = 3'd1,
    CB    = 3'd2,
    CR    = 3'd3,
    BITTI = 3'd4
  } durum_t;

  localparam logic [1:0] BILESEN_Y  = 2'd0;
  localparam logic [1:0] BILESEN_CB = 2'd1;
  localparam logic [1:0] BILESEN_CR = 2'd2;

  localparam int BLOK_PIKSEL = 64;

  // Component shown on bilesen_o for a given state; BITTI keeps the last one.
  function automatic logic [1:0] durum_bilesen(input durum_t d, input logic [1:0] eski);
    case (d)
      Y:       return BILESEN_Y;
      CB:      return BILESEN_CB;
      CR:      return BILESEN_CR;
      BITTI:   return eski;
      default: return BILESEN_Y;
    endcase
  endfunction

endpackage

// File: rtl/mcu_blok_siralayici_piksel.sv
// blok_piksel_sayaci: 6-bit raster pixel counter inside one 8x8 block with
// row/col/last-pixel decode. Wraps 63->0 on its own.
module blok_piksel_sayaci
  import mcu_blok_siralayici_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  fire,
  input  logic                  clear,
  output logic [`BLOCK_BIT-1:0] row,
  output logic [`BLOCK_BIT-1:0] col,
  output logic                  son
);

  logic [5:0] piks;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)    piks <= '0;
    else if (clear) piks <= '0;
    else if (fire)  piks <= piks + 6'd1;
  end

  assign row = piks[5:3];
  assign col = piks[2:0];
  assign son = (piks == 6'(BLOK_PIKSEL - 1));

endmodule

// File: rtl/mcu_blok_siralayici.sv
// Schedules Y/Cb/Cr block producers onto the shared IDCT path in MCU order.
// Optional stall cycle counter: define DN_SIRALAYICI_STALL_SAYAC_EN.
module mcu_blok_siralayici
  import mcu_blok_siralayici_pkg::*;
#(
  parameter int Y_BLOK  = 4,
  parameter int CB_BLOK = 1,
  parameter int CR_BLOK = 1,
  parameter int MCU_BIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  basla_i,
  input  logic [MCU_BIT-1:0]    cfg_mcu_sayisi_i,
  output logic                  mesgul_o,
  output logic                  bitti_o,
  input  logic [`PIXEL_BIT-1:0] y_veri_i,
  input  logic [`PIXEL_BIT-1:0] cb_veri_i,
  input  logic [`PIXEL_BIT-1:0] cr_veri_i,
  input  logic                  y_gecerli_i,
  input  logic                  cb_gecerli_i,
  input  logic                  cr_gecerli_i,
  output logic                  y_hazir_o,
  output logic                  cb_hazir_o,
  output logic                  cr_hazir_o,
  output logic [`PIXEL_BIT-1:0] idct_veri_o,
  output logic [`BLOCK_BIT-1:0] idct_row_o,
  output logic [`BLOCK_BIT-1:0] idct_col_o,
  output logic                  idct_gecerli_o,
  output logic                  idct_blok_son_o,
  input  logic                  idct_hazir_i,
  output logic [1:0]            bilesen_o
`ifdef DN_SIRALAYICI_STALL_SAYAC_EN
  ,
  output logic [31:0]           stall_sayac_o
`endif
);

  localparam logic [1:0] Y_SON  = 2'(Y_BLOK - 1);
  localparam logic [1:0] CB_SON = 2'(CB_BLOK - 1);
  localparam logic [1:0] CR_SON = 2'(CR_BLOK - 1);

  durum_t             durum, durum_n;
  logic [1:0]         blok_sayac;
  logic [MCU_BIT-1:0] mcu_sayac, cfg_q;
  logic [1:0]         bilesen_q;
  logic               sec_gecerli, fire, piks_son, blok_bitti, son_blok, mcu_son, basla_ok;

  // Mux is purely combinational so a consumer stall is seen by the producer same cycle.
  always_comb begin
    sec_gecerli = 1'b0;
    idct_veri_o = '0;
    y_hazir_o   = 1'b0;
    cb_hazir_o  = 1'b0;
    cr_hazir_o  = 1'b0;
    son_blok    = 1'b0;
    case (durum)
      Y: begin
        sec_gecerli = y_gecerli_i;
        idct_veri_o = y_veri_i;
        y_hazir_o   = idct_hazir_i;
        son_blok    = (blok_sayac == Y_SON);
      end
      CB: begin
        sec_gecerli = cb_gecerli_i;
        idct_veri_o = cb_veri_i;
        cb_hazir_o  = idct_hazir_i;
        son_blok    = (blok_sayac == CB_SON);
      end
      CR: begin
        sec_gecerli = cr_gecerli_i;
        idct_veri_o = cr_veri_i;
        cr_hazir_o  = idct_hazir_i;
        son_blok    = (blok_sayac == CR_SON);
      end
      default: ;
    endcase
  end

  assign idct_gecerli_o  = sec_gecerli;
  assign fire            = idct_gecerli_o && idct_hazir_i;
  assign blok_bitti      = fire && piks_son;
  assign idct_blok_son_o = piks_son && idct_gecerli_o;
  assign mcu_son         = (MCU_BIT'(mcu_sayac + 1'b1) == cfg_q);
  assign basla_ok        = (durum == BOSTA) && basla_i;
  assign mesgul_o        = (durum != BOSTA);
  assign bitti_o         = (durum == BITTI);
  assign bilesen_o       = bilesen_q;

  always_comb begin
    durum_n = durum;
    case (durum)
      BOSTA: if (basla_i) durum_n = (cfg_mcu_sayisi_i == '0) ? BITTI : Y;
      Y:     if (blok_bitti && son_blok) durum_n = CB;
      CB:    if (blok_bitti && son_blok) durum_n = CR;
      CR:    if (blok_bitti && son_blok) durum_n = mcu_son ? BITTI : Y;
      BITTI: durum_n = BOSTA;
      default: durum_n = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum      <= BOSTA;
      blok_sayac <= '0;
      mcu_sayac  <= '0;
      cfg_q      <= '0;
      bilesen_q  <= BILESEN_Y;
    end else begin
      durum     <= durum_n;
      bilesen_q <= durum_bilesen(durum_n, bilesen_q);
      if (basla_ok) begin
        cfg_q     <= cfg_mcu_sayisi_i;
        mcu_sayac <= '0;
      end else if ((durum == CR) && blok_bitti && son_blok) begin
        mcu_sayac <= mcu_sayac + 1'b1;
      end
      if (durum_n != durum) blok_sayac <= '0;
      else if (blok_bitti)  blok_sayac <= blok_sayac + 2'd1;
    end
  end

  blok_piksel_sayaci u_piksel (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .fire   (fire),
    .clear  (durum == BOSTA),
    .row    (idct_row_o),
    .col    (idct_col_o),
    .son    (piks_son)
  );

`ifdef DN_SIRALAYICI_STALL_SAYAC_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                  stall_sayac_o <= '0;
    else if (basla_ok)            stall_sayac_o <= '0;
    else if (idct_gecerli_o && !idct_hazir_i && (stall_sayac_o != 32'hFFFF_FFFF))
                                  stall_sayac_o <= stall_sayac_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mcu_blok_siralayici.sv
// Scoreboard bench for mcu_blok_siralayici: producers feed random pixels,
// the expected MCU-ordered stream is queued up front and a negedge monitor checks it.
`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif
`ifndef BLOCK_BIT
`define BLOCK_BIT 3
`endif

module tb_mcu_blok_siralayici;
  localparam int NY = 4, NCB = 1, NCR = 1, MB = 16, PB = `PIXEL_BIT;

  logic clk_i = 1'b0, rstn_i = 1'b0, basla_i = 1'b0;
  logic [MB-1:0] cfg_i = '0;
  logic mesgul_o, bitti_o;
  logic [PB-1:0] y_veri_i = '0, cb_veri_i = '0, cr_veri_i = '0, idct_veri_o;
  logic y_gecerli_i = 1'b0, cb_gecerli_i = 1'b0, cr_gecerli_i = 1'b0;
  logic y_hazir_o, cb_hazir_o, cr_hazir_o;
  logic [2:0] idct_row_o, idct_col_o;
  logic idct_gecerli_o, idct_blok_son_o, idct_hazir_i = 1'b0;
  logic [1:0] bilesen_o;
`ifdef DN_SIRALAYICI_STALL_SAYAC_EN
  logic [31:0] stall_sayac_o;
`endif

  always #5 clk_i = ~clk_i;

  mcu_blok_siralayici #(.Y_BLOK(NY), .CB_BLOK(NCB), .CR_BLOK(NCR), .MCU_BIT(MB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .basla_i(basla_i), .cfg_mcu_sayisi_i(cfg_i),
    .mesgul_o(mesgul_o), .bitti_o(bitti_o),
    .y_veri_i(y_veri_i), .cb_veri_i(cb_veri_i), .cr_veri_i(cr_veri_i),
    .y_gecerli_i(y_gecerli_i), .cb_gecerli_i(cb_gecerli_i), .cr_gecerli_i(cr_gecerli_i),
    .y_hazir_o(y_hazir_o), .cb_hazir_o(cb_hazir_o), .cr_hazir_o(cr_hazir_o),
    .idct_veri_o(idct_veri_o), .idct_row_o(idct_row_o), .idct_col_o(idct_col_o),
    .idct_gecerli_o(idct_gecerli_o), .idct_blok_son_o(idct_blok_son_o),
`ifdef DN_SIRALAYICI_STALL_SAYAC_EN
    .stall_sayac_o(stall_sayac_o),
`endif
    .idct_hazir_i(idct_hazir_i), .bilesen_o(bilesen_o)
  );

  typedef struct packed {
    logic [1:0]    c;
    logic [PB-1:0] d;
    logic [2:0]    r;
    logic [2:0]    k;
    logic          s;
  } exp_t;

  logic [PB-1:0] yq[$], cbq[$], crq[$];
  exp_t expq[$];

  int tests = 0, fails = 0;
  int cyc = 0, n_fire = 0, last_fire_cyc = -1, bitti_cyc = -1, start_cyc = -1, stall_tb = 0;
  bit saw_bitti = 0;
  int hmode = 0, vmode = 0;
  bit en_y = 1, en_cb = 1, en_cr = 1;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endfunction

  // Monitor: every cycle checks handshake routing and the pixel at the head of the queue.
  exp_t e;
  logic [1:0] ec;
  bit act, sel_v;
  always @(negedge clk_i) begin
    cyc++;
    act = mesgul_o && !bitti_o;
    ec  = (expq.size() > 0) ? expq[0].c : 2'd3;
    sel_v = (ec == 2'd0) ? y_gecerli_i : (ec == 2'd1) ? cb_gecerli_i : (ec == 2'd2) ? cr_gecerli_i : 1'b0;
    chk("hazir_yonlendirme", 64'({y_hazir_o, cb_hazir_o, cr_hazir_o}),
        64'({act && idct_hazir_i && ec == 2'd0, act && idct_hazir_i && ec == 2'd1,
             act && idct_hazir_i && ec == 2'd2}));
    chk("idct_gecerli", 64'(idct_gecerli_o), 64'(act && sel_v));
    if (act) chk("bilesen", 64'(bilesen_o), 64'(ec));
    if (!mesgul_o) chk("bosta_cikis", 64'({bilesen_o, idct_gecerli_o}), 64'd0);
    if (!idct_gecerli_o) chk("blok_son_gecersiz", 64'(idct_blok_son_o), 64'd0);
    if (idct_gecerli_o && expq.size() > 0) begin
      e = expq[0];
      chk("piksel", 64'({idct_veri_o, idct_row_o, idct_col_o, idct_blok_son_o}),
          64'({e.d, e.r, e.k, e.s}));
    end
    if (idct_gecerli_o && idct_hazir_i) begin
      if (expq.size() == 0) chk("fazla_fire", 64'd1, 64'd0);
      else void'(expq.pop_front());
      n_fire++;
      last_fire_cyc = cyc;
    end
    if (idct_gecerli_o && !idct_hazir_i) stall_tb++;
    if (bitti_o) begin saw_bitti = 1; bitti_cyc = cyc; end
    if (basla_i && !mesgul_o) start_cyc = cyc;
  end

  task automatic drive();
    y_gecerli_i  = en_y  && yq.size()  > 0 && (vmode == 0 || $urandom_range(0, 3) != 0);
    cb_gecerli_i = en_cb && cbq.size() > 0 && (vmode == 0 || $urandom_range(0, 3) != 0);
    cr_gecerli_i = en_cr && crq.size() > 0 && (vmode == 0 || $urandom_range(0, 3) != 0);
    y_veri_i  = (yq.size()  > 0) ? yq[0]  : '0;
    cb_veri_i = (cbq.size() > 0) ? cbq[0] : '0;
    cr_veri_i = (crq.size() > 0) ? crq[0] : '0;
    case (hmode)
      0:       idct_hazir_i = 1'b1;
      1:       idct_hazir_i = !idct_hazir_i;
      default: idct_hazir_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic step();
    bit hy, hc, hr;
    @(negedge clk_i);
    hy = y_gecerli_i && y_hazir_o;
    hc = cb_gecerli_i && cb_hazir_o;
    hr = cr_gecerli_i && cr_hazir_o;
    @(posedge clk_i);
    #1;
    if (hy) void'(yq.pop_front());
    if (hc) void'(cbq.pop_front());
    if (hr) void'(crq.pop_front());
    basla_i = 1'b0;
    drive();
  endtask

  // Reference stream: MCU by MCU, Y blocks then Cb then Cr, 64 raster pixels each.
  task automatic build(input int cfg);
    exp_t x;
    logic [PB-1:0] d;
    int nb;
    for (int m = 0; m < cfg; m++)
      for (int c = 0; c < 3; c++) begin
        nb = (c == 0) ? NY : (c == 1) ? NCB : NCR;
        for (int b = 0; b < nb; b++)
          for (int p = 0; p < 64; p++) begin
            d = PB'($urandom);
            if (c == 0) yq.push_back(d);
            else if (c == 1) cbq.push_back(d);
            else crq.push_back(d);
            x.c = 2'(c); x.d = d; x.r = 3'(p / 8); x.k = 3'(p % 8); x.s = (p == 63);
            expq.push_back(x);
          end
      end
  endtask

  task automatic run_job(input int cfg, input int hm, input int vm, input int rst_at,
                         input int ign_at, input bit cb_hold, input int exp_f);
    int hold;
    bit ign_done;
    hmode = hm; vmode = vm;
    en_y = 1; en_cb = !cb_hold; en_cr = 1;
    hold = 0; ign_done = 0;
    build(cfg);
    n_fire = 0; saw_bitti = 0; stall_tb = 0; bitti_cyc = -1; last_fire_cyc = -1; start_cyc = -1;
    basla_i = 1'b1; cfg_i = MB'(cfg);
    drive();
    for (int t = 0; t < 20000 && !saw_bitti; t++) begin
      step();
      if (rst_at > 0 && n_fire >= rst_at) begin
        rstn_i = 1'b0;
        yq.delete(); cbq.delete(); crq.delete(); expq.delete();
        drive();
        #3 rstn_i = 1'b1;
        return;
      end
      if (ign_at > 0 && !ign_done && n_fire >= ign_at) begin
        basla_i = 1'b1; cfg_i = MB'(5); ign_done = 1;
      end
      if (cb_hold && !en_cb && bilesen_o == 2'd1) begin
        hold++;
        if (hold >= 100) begin en_cb = 1; cb_gecerli_i = (cbq.size() > 0); end
      end
    end
    chk("bitti_goruldu", 64'(saw_bitti), 64'd1);
    chk("fire_sayisi", 64'(n_fire), 64'(exp_f));
    chk("kuyruk_bos", 64'(expq.size()), 64'd0);
    if (cfg > 0) chk("bitti_zaman", 64'(bitti_cyc), 64'(last_fire_cyc + 1));
    else         chk("bitti_zaman", 64'(bitti_cyc), 64'(start_cyc + 1));
    chk("bosta_donus", 64'({mesgul_o, bitti_o}), 64'd0);
    if (cb_hold) chk("cb_bekleme", 64'(hold), 64'd100);
`ifdef DN_SIRALAYICI_STALL_SAYAC_EN
    chk("stall_sayac", 64'(stall_sayac_o), 64'(stall_tb));
`endif
    cfg_i = '0;
    step();
  endtask

  initial begin
    int c;
    drive();
    repeat (2) @(negedge clk_i);
    chk("reset_cikis", 64'({mesgul_o, bitti_o, y_hazir_o, cb_hazir_o, cr_hazir_o, idct_gecerli_o,
                            idct_blok_son_o, bilesen_o}), 64'd0);
    chk("reset_veri", 64'({idct_veri_o, idct_row_o, idct_col_o}), 64'd0);
    @(posedge clk_i); #1 rstn_i = 1'b1;
    step();

    run_job(1, 0, 0, 0, 0, 0, 384);    // full-rate single MCU
    run_job(0, 0, 0, 0, 0, 0, 0);      // zero-count job
    run_job(2, 1, 0, 0, 0, 0, 768);    // toggling consumer ready
    run_job(1, 0, 0, 0, 0, 1, 384);    // Cb producer absent at the switch
    run_job(1, 0, 0, 30, 0, 0, 0);     // reset mid-block
    step();
    run_job(1, 0, 0, 0, 0, 0, 384);
    run_job(1, 0, 0, 0, 100, 0, 384);  // restart request while busy
    for (int k = 0; k < 3; k++) begin
      c = $urandom_range(1, 3);
      run_job(c, 2, 1, 0, 0, 0, c * 384);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcu_blok_siralayici.md
Name: mcu_blok_siralayici

Overview:
- Schedules the shared IDCT→decode_normalizer path between three per-component block producers (Y, Cb, Cr).
- Forwards whole 8x8 blocks in fixed MCU order: Y_BLOK Y blocks, then CB_BLOK Cb blocks, then CR_BLOK Cr blocks. Repeats for a configured number of MCUs.
- Generates the row, col and blok_son sideband for the downstream consumer.
- Sits between the component sample buffers and the decode_normalizer input.

Parameters:
- Y_BLOK, 4, Y blocks per MCU (4 = 4:2:0); legal range 1..4.
- CB_BLOK, 1, Cb blocks per MCU; legal range 1..2.
- CR_BLOK, 1, Cr blocks per MCU; legal range 1..2.
- MCU_BIT, 16, width of the MCU count and MCU counter.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- basla_i  in  1  start pulse; sampled only in BOSTA.
- cfg_mcu_sayisi_i  in  MCU_BIT  number of MCUs; latched on an accepted basla_i.
- mesgul_o  out  1  high in any state except BOSTA.
- bitti_o  out  1  one-cycle pulse when the last block is accepted or a zero-count job ends.
- y_veri_i / cb_veri_i / cr_veri_i  in  `PIXEL_BIT  producer pixel data, raster order within the block.
- y_gecerli_i / cb_gecerli_i / cr_gecerli_i  in  1  producer valid.
- y_hazir_o / cb_hazir_o / cr_hazir_o  out  1  producer ready.
- idct_veri_o  out  `PIXEL_BIT  selected pixel.
- idct_row_o, idct_col_o  out  `BLOCK_BIT each  pixel position within the block.
- idct_gecerli_o  out  1  valid to consumer.
- idct_blok_son_o  out  1  marks the 64th pixel of a block.
- idct_hazir_i  in  1  consumer ready.
- bilesen_o  out  2  current component: 0 = Y, 1 = Cb, 2 = Cr.

Behaviour:
- Reset values: all outputs 0, state BOSTA, all counters 0.
- States:
  - BOSTA → Y on basla_i when cfg != 0.
  - BOSTA → BITTI on basla_i when cfg == 0.
  - Y → CB after the Y_BLOK-th Y block completes.
  - CB → CR after the CB_BLOK-th Cb block completes.
  - CR → Y if more MCUs remain, else → BITTI.
  - BITTI → BOSTA unconditionally after 1 cycle; bitti_o = 1 in BITTI only.
- Zero-latency combinational mux:
  - idct_veri_o = selected producer's data.
  - idct_gecerli_o = selected gecerli_i AND state ∈ {Y, CB, CR}.
  - Selected hazir_o = idct_hazir_i. Non-selected hazir_o = 0. All hazir_o = 0 in BOSTA and BITTI.
- Transfer (fire) = idct_gecerli_o AND idct_hazir_i.
- Pixel counter piks[5:0] increments on fire.
  - idct_row_o = piks[5:3], idct_col_o = piks[2:0].
  - idct_blok_son_o = (piks == 63) AND idct_gecerli_o.
  - Wraps 63→0 on the fire of the block's last pixel; the block counter advances on that same edge.
- Block counter counts within the current component and clears on each component change.
- MCU counter increments when the last Cr block completes. Completion compares against the latched cfg value.
- The component changes only at a block boundary; a block is never split across producers.
- Consumer stall (gecerli=1, hazir=0): data, row and col must stay stable. They do, because the producer holds its data and piks does not move.
- basla_i while mesgul_o = 1 is ignored; the latched config is unchanged.
- An asynchronous reset mid-block drops the partial block; the next job starts at piks = 0.
- bilesen_o holds the last component in BITTI and returns to 0 in BOSTA.

Optional Feature:
- Macro: DN_SIRALAYICI_STALL_SAYAC_EN.
- With the macro defined:
  - Adds output stall_sayac_o (32 bits).
  - Counts cycles in Y/CB/CR where idct_gecerli_o = 1 and idct_hazir_i = 0.
  - Saturates at 0xFFFFFFFF.
  - Clears on an accepted basla_i; holds its value after BITTI.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared header/package holds:
  - State encoding: BOSTA = 0, Y = 1, CB = 2, CR = 3, BITTI = 4.
  - Component IDs: BILESEN_Y = 0, BILESEN_CB = 1, BILESEN_CR = 2.
  - BLOK_PIKSEL = 64.
  - Reuses the existing `PIXEL_BIT / `BLOCK_BIT.
- One natural sub-module: blok_piksel_sayaci.
  - Contains the 6-bit pixel counter and the row/col/blok_son decode.
  - Inputs: fire and clear. Outputs: row, col, son.

Test Plan:
1. Config defaults, cfg = 1, all producers always valid, hazir_i = 1 → exactly 384 fires. bilesen_o sequence: 256 cycles 0, 64 cycles 1, 64 cycles 2. blok_son on fires 64, 128, …, 384. bitti_o pulses 1 cycle after fire 384.
2. cfg = 0 with basla_i → no hazir_o ever high; bitti_o high exactly 1 cycle after basla_i; back in BOSTA on the next cycle.
3. cfg = 2, hazir_i toggling 1/0 each cycle → 768 fires. Data, row and col stable during every stall. Pixel values received in raster order per block, with row/col matching the pixel index. With DN_SIRALAYICI_STALL_SAYAC_EN, stall_sayac_o = 767.
4. cb_gecerli_i held 0 for 100 cycles at the Y→CB switch → idct_gecerli_o = 0, y_hazir_o and cr_hazir_o = 0, no Cr data forwarded; resumes with Cb pixel 0 at row 0, col 0.
5. rstn_i asserted at Y pixel 30 of MCU 0, then basla_i with cfg = 1 → first fire after restart has row 0, col 0, bilesen_o = 0; the full 384-pixel job completes.
6. basla_i pulsed mid-job with cfg = 5 → ignored. The job ends after the originally latched count (cfg = 1, 384 fires).
